// File: rtl/sprite_pkg.sv
// Shared sprite-engine definitions: register map, commit FSM states and
// sprite-entry layout, used by the shadow register block and the display engine.
package sprite_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned HC_W    = 11;
    localparam int unsigned VC_W    = 10;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned IMG_W   = 5;
    localparam int unsigned BND_W   = 10;

    localparam int unsigned NUM_BND = 4;
    localparam int unsigned NUM_SPR = 2;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_BND1    = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_BND2    = 6'h01;
    localparam logic [ADDR_W-1:0] ADDR_BND3    = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_BND4    = 6'h03;
    localparam logic [ADDR_W-1:0] ADDR_S1_X    = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_S1_Y    = 6'h05;
    localparam logic [ADDR_W-1:0] ADDR_S1_IMG  = 6'h06;
    localparam logic [ADDR_W-1:0] ADDR_S2_X    = 6'h07;
    localparam logic [ADDR_W-1:0] ADDR_S2_Y    = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_S2_IMG  = 6'h09;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 6'h0A;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_CLR = 6'h0B;
    localparam logic [ADDR_W-1:0] ADDR_FCNT    = 6'h0C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Field order gives {img, y, x} with x in the least significant bits
    typedef struct packed {
        logic [IMG_W-1:0] img;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   x;
    } sprite_t;

    localparam int unsigned SPRITE_W = $bits(sprite_t);

endpackage

// File: rtl/frame_tick.sv
// Frame-start detector: pulses for the cycle in which the display counters
// sit at the start of the commit line.
module frame_tick
    import sprite_pkg::*;
#(
    parameter logic [VC_W-1:0] COMMIT_LINE = 10'd480
) (
    input  logic [HC_W-1:0] hcount,
    input  logic [VC_W-1:0] vcount,
    output logic            frame_pulse_c
);

    // Counters advance every clock, so the match lasts exactly one cycle
    assign frame_pulse_c = (hcount == HC_W'(0)) && (vcount == COMMIT_LINE);

endmodule

// File: rtl/sprite_shadow_regs.sv
// Avalon-mapped shadow registers for sprite/boundary state, copied atomically
// to the active outputs at the first frame start after software arms a commit.
module sprite_shadow_regs
    import sprite_pkg::*;
#(
    parameter logic [VC_W-1:0] COMMIT_LINE = 10'd480,
    parameter int unsigned     FCNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic                        read,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           writedata,
    output logic [DATA_W-1:0]           readdata,
    output logic                        irq,
    input  logic [HC_W-1:0]             hcount,
    input  logic [VC_W-1:0]             vcount,
    output logic [NUM_BND*BND_W-1:0]    act_boundary,
    output logic [NUM_SPR*SPRITE_W-1:0] act_sprite
);

    logic [NUM_BND-1:0][BND_W-1:0] shd_bnd_q;
    logic [NUM_BND-1:0][BND_W-1:0] act_bnd_q;
    sprite_t [NUM_SPR-1:0]         shd_spr_q;
    sprite_t [NUM_SPR-1:0]         act_spr_q;
    logic [FCNT_W-1:0]             fcnt_q;
    state_t                        state_q;
    state_t                        state_d;

    logic                          frame_pulse_c;
    logic                          wr_c;
    logic                          rd_c;
    logic                          arm_wr_c;
    logic                          irq_clr_c;
    logic                          commit_c;
    logic [DATA_W-1:0]             rd_data_c;
    logic                          unused_wdata;

    frame_tick #(
        .COMMIT_LINE (COMMIT_LINE)
    ) u_frame_tick (
        .hcount        (hcount),
        .vcount        (vcount),
        .frame_pulse_c (frame_pulse_c)
    );

    assign wr_c         = chipselect && write;
    assign rd_c         = chipselect && read;
    assign arm_wr_c     = wr_c && (address == ADDR_CTRL);
    assign irq_clr_c    = wr_c && (address == ADDR_IRQ_CLR);
    assign unused_wdata = ^writedata[DATA_W-1:BND_W];

    assign act_boundary = act_bnd_q;
    assign act_sprite   = act_spr_q;

    // Commit FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next state; an arm seen during COMMIT re-arms for the next frame
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_wr_c && writedata[0]) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (arm_wr_c && !writedata[0]) begin
                    state_d = ST_IDLE;
                end else if (frame_pulse_c) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                state_d  = (arm_wr_c && writedata[0]) ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow registers: software-visible, never drive the display directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shd_bnd_q <= '0;
            shd_spr_q <= '0;
        end else if (wr_c) begin
            case (address)
                ADDR_BND1:   shd_bnd_q[0]     <= writedata[BND_W-1:0];
                ADDR_BND2:   shd_bnd_q[1]     <= writedata[BND_W-1:0];
                ADDR_BND3:   shd_bnd_q[2]     <= writedata[BND_W-1:0];
                ADDR_BND4:   shd_bnd_q[3]     <= writedata[BND_W-1:0];
                ADDR_S1_X:   shd_spr_q[0].x   <= writedata[X_W-1:0];
                ADDR_S1_Y:   shd_spr_q[0].y   <= writedata[Y_W-1:0];
                ADDR_S1_IMG: shd_spr_q[0].img <= writedata[IMG_W-1:0];
                ADDR_S2_X:   shd_spr_q[1].x   <= writedata[X_W-1:0];
                ADDR_S2_Y:   shd_spr_q[1].y   <= writedata[Y_W-1:0];
                ADDR_S2_IMG: shd_spr_q[1].img <= writedata[IMG_W-1:0];
                default: ;
            endcase
        end
    end

    // Active copy samples the shadow before any same-cycle write lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_bnd_q <= '0;
            act_spr_q <= '0;
        end else if (commit_c) begin
            act_bnd_q <= shd_bnd_q;
            act_spr_q <= shd_spr_q;
        end
    end

    // Commit-done interrupt; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (commit_c) begin
            irq <= 1'b1;
        end else if (irq_clr_c) begin
            irq <= 1'b0;
        end
    end

    // Free-running frame counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
        end else if (frame_pulse_c) begin
            fcnt_q <= fcnt_q + FCNT_W'(1);
        end
    end

    // Read mux built from current (pre-write) register contents
    always_comb begin
        rd_data_c = '0;
        case (address)
            ADDR_BND1:    rd_data_c = DATA_W'(shd_bnd_q[0]);
            ADDR_BND2:    rd_data_c = DATA_W'(shd_bnd_q[1]);
            ADDR_BND3:    rd_data_c = DATA_W'(shd_bnd_q[2]);
            ADDR_BND4:    rd_data_c = DATA_W'(shd_bnd_q[3]);
            ADDR_S1_X:    rd_data_c = DATA_W'(shd_spr_q[0].x);
            ADDR_S1_Y:    rd_data_c = DATA_W'(shd_spr_q[0].y);
            ADDR_S1_IMG:  rd_data_c = DATA_W'(shd_spr_q[0].img);
            ADDR_S2_X:    rd_data_c = DATA_W'(shd_spr_q[1].x);
            ADDR_S2_Y:    rd_data_c = DATA_W'(shd_spr_q[1].y);
            ADDR_S2_IMG:  rd_data_c = DATA_W'(shd_spr_q[1].img);
            ADDR_CTRL:    rd_data_c = DATA_W'({(state_q == ST_COMMIT), (state_q == ST_ARMED)});
            ADDR_IRQ_CLR: rd_data_c = DATA_W'(irq);
            ADDR_FCNT:    rd_data_c = DATA_W'(fcnt_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_c) begin
            readdata <= rd_data_c;
        end
    end

endmodule
